// File: rtl/uart_rx_param.sv
// uart_rx_param: UART receiver with runtime 5..8 data bits, optional parity,
// 1/2 stop bits, 3-sample majority voting, false-start rejection and a
// show-ahead FIFO holding {perr, ferr, data} with overrun detection.
// Optional feature macro: UART_RX_BREAK_EN (break detection, break frames
// are not pushed and the receiver waits for the line to go high again).
`timescale 1ns/1ps

module uart_rx_param #(
    parameter int BAUD_W     = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              mclk,
    input  logic              n_reset,
    input  logic [BAUD_W-1:0] baud_max_cnt,
    input  logic [1:0]        data_bits,
    input  logic [1:0]        parity_sel,
    input  logic              stop_sel,
    input  logic              read_en,
    input  logic              rxd,
    output logic [7:0]        rd_data,
    output logic              rd_perr,
    output logic              rd_ferr,
    output logic              rd_valid,
    output logic              full,
    output logic [AW:0]       level,
    output logic              overrun,
    input  logic              clr_err,
    output logic              break_det
);

`ifdef UART_RX_BREAK_EN
    localparam bit BRK_EN = 1'b1;
`else
    localparam bit BRK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_PUSH, S_BWAIT
    } state_t;

    state_t            r_state;
    logic              r_sync1, r_rxd_s, r_rxd_d;
    logic [BAUD_W-1:0] r_cnt;
    logic              r_s0, r_s1;
    logic [7:0]        r_shift;
    logic [2:0]        r_bitn;
    logic              r_par, r_ferr, r_stop1_low, r_brk;

    logic [9:0]        r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wp, r_rp;
    logic [AW:0]       r_level;
    logic              r_overrun;

    logic [BAUD_W-1:0] w_mid;
    logic              w_dec, w_end, w_bit, w_last, w_par_en, w_perr;
    logic              w_bitstate, w_stop1_low, w_brk_cond;
    logic              w_push, w_pop, w_wr, w_ovf, w_full;
    logic [9:0]        w_head;

    assign w_mid       = baud_max_cnt >> 1;
    assign w_dec       = (r_cnt == w_mid + BAUD_W'(1));
    assign w_end       = (r_cnt == baud_max_cnt);
    // Majority of the three samples around the bit centre.
    assign w_bit       = (r_s0 & r_s1) | (r_s0 & r_rxd_s) | (r_s1 & r_rxd_s);
    assign w_last      = (r_bitn == ({1'b0, data_bits} + 3'd4));
    assign w_par_en    = (parity_sel == 2'd1) || (parity_sel == 2'd2);
    assign w_perr      = w_par_en && ((^r_shift ^ r_par) != (parity_sel == 2'd2));
    assign w_bitstate  = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP1) ||
                         (r_state == S_STOP2);
    // STOP1 level: live decision when leaving from STOP1, latched otherwise.
    assign w_stop1_low = (r_state == S_STOP1) ? !w_bit : r_stop1_low;
    assign w_brk_cond  = BRK_EN && (r_shift == 8'd0) && !r_par && w_stop1_low;

    // Two-flop synchroniser plus a delay flop for falling-edge detection.
    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1 <= 1'b1;
            r_rxd_s <= 1'b1;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rxd_s <= r_sync1;
            r_rxd_d <= r_rxd_s;
        end
    end

    // Frame FSM: bit timing, sampling, shifting and error capture.
    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_shift     <= '0;
            r_bitn      <= '0;
            r_par       <= 1'b0;
            r_ferr      <= 1'b0;
            r_stop1_low <= 1'b0;
            r_brk       <= 1'b0;
        end else begin
            r_brk <= 1'b0;
            if (w_bitstate) begin
                r_cnt <= w_end ? '0 : r_cnt + BAUD_W'(1);
                if (r_cnt == w_mid - BAUD_W'(1)) r_s0 <= r_rxd_s;
                if (r_cnt == w_mid)              r_s1 <= r_rxd_s;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_rxd_d && !r_rxd_s) begin
                        r_state     <= S_START;
                        r_cnt       <= '0;
                        r_shift     <= '0;
                        r_bitn      <= '0;
                        r_par       <= 1'b0;
                        r_ferr      <= 1'b0;
                        r_stop1_low <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_dec && w_bit) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_end) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_dec) r_shift[r_bitn] <= w_bit;
                    if (w_end) begin
                        if (w_last) r_state <= w_par_en ? S_PARITY : S_STOP1;
                        else        r_bitn  <= r_bitn + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (w_dec) r_par <= w_bit;
                    if (w_end) r_state <= S_STOP1;
                end
                S_STOP1: begin
                    if (w_dec) begin
                        r_ferr      <= !w_bit;
                        r_stop1_low <= !w_bit;
                        if (!stop_sel) begin
                            r_state <= S_PUSH;
                            r_brk   <= w_brk_cond;
                        end
                    end else if (w_end && stop_sel) begin
                        r_state <= S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (w_dec) begin
                        r_ferr  <= r_ferr | !w_bit;
                        r_state <= S_PUSH;
                        r_brk   <= w_brk_cond;
                    end
                end
                S_PUSH: begin
                    r_cnt   <= '0;
                    r_state <= (BRK_EN && r_brk) ? S_BWAIT : S_IDLE;
                end
                S_BWAIT: begin
                    if (r_rxd_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_full = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_push = (r_state == S_PUSH) && !r_brk;
    assign w_pop  = read_en && (r_level != '0);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_ovf  = w_push && w_full && !w_pop;

    // FIFO storage: entries are {perr, ferr, data}.
    always_ff @(posedge mclk) begin
        if (w_wr) r_mem[r_wp] <= {w_perr, r_ferr, r_shift};
    end

    // FIFO pointers, occupancy and sticky overrun (set wins over clear).
    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            if (w_ovf)        r_overrun <= 1'b1;
            else if (clr_err) r_overrun <= 1'b0;
        end
    end

    assign w_head   = r_mem[r_rp];
    assign rd_valid = (r_level != '0);
    assign rd_data  = rd_valid ? w_head[7:0] : 8'd0;
    assign rd_ferr  = rd_valid & w_head[8];
    assign rd_perr  = rd_valid & w_head[9];
    assign full     = w_full;
    assign level    = r_level;
    assign overrun  = r_overrun;
`ifdef UART_RX_BREAK_EN
    assign break_det = r_brk;
`else
    assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param (bit period 16 clocks, FIFO depth 4).
`timescale 1ns/1ps

module tb_uart_rx_param;
    localparam int BIT   = 16;
    localparam int DEPTH = 4;
    // rxd fall -> rd_valid rise for 8N1: 3 clocks to START, 9 bit periods to
    // STOP1, decision at cnt=mid+1 (seen one edge later), write one edge after.
    localparam int LAT_8N1 = 3 + BIT*9 + (BIT/2 + 1) + 1;

    logic        mclk, n_reset, stop_sel, read_en, rxd, clr_err;
    logic [15:0] baud_max_cnt;
    logic [1:0]  data_bits, parity_sel;
    logic [7:0]  rd_data;
    logic        rd_perr, rd_ferr, rd_valid, full, overrun, break_det;
    logic [2:0]  level;

    int n_tot = 0;
    int n_bad = 0;
    int brk_cnt = 0;
    logic [9:0] sb[$];

    uart_rx_param #(.BAUD_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .mclk(mclk), .n_reset(n_reset), .baud_max_cnt(baud_max_cnt),
        .data_bits(data_bits), .parity_sel(parity_sel), .stop_sel(stop_sel),
        .read_en(read_en), .rxd(rxd), .rd_data(rd_data), .rd_perr(rd_perr),
        .rd_ferr(rd_ferr), .rd_valid(rd_valid), .full(full), .level(level),
        .overrun(overrun), .clr_err(clr_err), .break_det(break_det)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    always @(posedge mclk) if (break_det) brk_cnt <= brk_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_brk"}, break_det, 0);
        chk({tag, "_data"}, {rd_perr, rd_ferr, rd_data}, 0);
    endtask

    // Drive one frame; queue the expected entry when push_exp is set.
    // glb: data bit index that gets a one-clock inversion at its centre (-1 none).
    task automatic send(input logic [7:0] d, input int nb, input int pm, input int ns,
                        input bit flip, input bit stop0, input int glb, input bit push_exp);
        logic b [12];
        logic [7:0] dm;
        logic p;
        int n;
        dm = d & ((8'd1 << nb) - 8'd1);
        n = 0;
        b[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin b[n] = d[i]; n++; end
        if (pm != 0) begin
            p = ^dm;
            if (pm == 2) p = ~p;
            if (flip) p = ~p;
            b[n] = p; n++;
        end
        b[n] = ~stop0; n++;
        if (ns == 2) begin b[n] = 1'b1; n++; end
        if (push_exp) sb.push_back({(pm != 0) && flip, stop0, dm});
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < BIT; k++) begin
                rxd = (glb == i - 1 && k == 8) ? ~b[i] : b[i];
                clk(1);
            end
        end
        rxd = 1'b1;
        clk(8);
    endtask

    task automatic drain(input string tag);
        logic [9:0] e;
        int g = 0;
        while (rd_valid && g < 2*DEPTH + 2) begin
            g++;
            if (sb.size() == 0) begin
                chk({tag, "_extra"}, rd_valid, 0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_data"}, rd_data, e[7:0]);
                chk({tag, "_ferr"}, rd_ferr, e[8]);
                chk({tag, "_perr"}, rd_perr, e[9]);
            end
            read_en = 1'b1; clk(1); read_en = 1'b0;
        end
        chk({tag, "_missing"}, sb.size(), 0);
        chk({tag, "_empty"}, level, 0);
    endtask

    initial begin
        int n;
        int b0;
        logic [9:0] e;
        n_reset = 1'b0; rxd = 1'b1; read_en = 1'b0; clr_err = 1'b0;
        baud_max_cnt = 16'(BIT - 1); data_bits = 2'd3; parity_sel = 2'd0; stop_sel = 1'b0;
        clk(3);
        chk_reset("rst");
        n_reset = 1'b1;
        clk(3);
        chk_reset("rst_rel");

        // 8N1 0xA5 with write latency measured from the start edge
        n = 0;
        fork
            send(8'hA5, 8, 0, 1, 0, 0, -1, 1);
            begin
                while (!rd_valid && n < 400) begin clk(1); n++; end
                chk("lat_8n1", n, LAT_8N1);
            end
        join
        chk("lvl_1", level, 1);
        drain("a5");

        // 7E2: good parity then flipped parity
        data_bits = 2'd2; parity_sel = 2'd1; stop_sel = 1'b1;
        send(8'h55, 7, 1, 2, 0, 0, -1, 1);
        send(8'h55, 7, 1, 2, 1, 0, -1, 1);
        drain("7e2");

        // 5O1: upper bits masked off
        data_bits = 2'd0; parity_sel = 2'd2; stop_sel = 1'b0;
        send(8'hF3, 5, 2, 1, 0, 0, -1, 1);
        drain("5o1");

        // Glitches on idle line are rejected as false starts
        data_bits = 2'd3; parity_sel = 2'd0;
        rxd = 1'b0; clk(1); rxd = 1'b1; clk(3*BIT);
        rxd = 1'b0; clk(3); rxd = 1'b1; clk(3*BIT);
        chk("glitch_lvl", level, 0);
        // One-clock inversion at a data bit centre is outvoted
        send(8'hC3, 8, 0, 1, 0, 0, 2, 1);
        drain("mid_glitch");

        // Fill FIFO, fifth frame overruns and is lost
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 8, 0, 1, 0, 0, -1, i < 4);
        chk("ff_full", full, 1);
        chk("ff_level", level, 4);
        chk("ff_ovr", overrun, 1);
        clr_err = 1'b1; clk(1); clr_err = 1'b0;
        chk("ff_clr", overrun, 0);
        // Push and pop on the same edge while full
        fork
            send(8'h77, 8, 0, 1, 0, 0, -1, 1);
            begin
                clk(LAT_8N1 - 1);
                e = sb.pop_front();
                chk("pp_head", rd_data, e[7:0]);
                read_en = 1'b1; clk(1); read_en = 1'b0;
                chk("pp_level", level, 4);
            end
        join
        chk("pp_level2", level, 4);
        chk("pp_ovr", overrun, 0);
        drain("ff");

        // Stop bit forced low -> frame error
        send(8'h3C, 8, 0, 1, 0, 1, -1, 1);
        drain("ferr");

        // Line held low for two frames
        b0 = brk_cnt;
`ifndef UART_RX_BREAK_EN
        sb.push_back({1'b0, 1'b1, 8'h00});
`endif
        rxd = 1'b0; clk(20*BIT); rxd = 1'b1; clk(2*BIT);
`ifdef UART_RX_BREAK_EN
        chk("brk_pulses", brk_cnt - b0, 1);
`else
        chk("brk_pulses", brk_cnt - b0, 0);
`endif
        drain("brk");
        send(8'h5A, 8, 0, 1, 0, 0, -1, 1);
        drain("post_brk");

        // Reset mid-DATA with two entries queued
        send(8'h11, 8, 0, 1, 0, 0, -1, 1);
        send(8'h22, 8, 0, 1, 0, 0, -1, 1);
        chk("pre_rst_lvl", level, 2);
        rxd = 1'b0; clk(50);
        n_reset = 1'b0; #1;
        chk_reset("mid_rst");
        rxd = 1'b1;
        sb.delete();
        clk(3);
        n_reset = 1'b1;
        clk(3);
        send(8'h81, 8, 0, 1, 0, 0, -1, 1);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
